cpu_elastic_buffer: RTL
=======================

# cpu_elastic_buffer

Parametrised N-entry elastic buffer for inter-stage decoupling in the CPU pipeline; carries a tag and a DW-bit payload from a producer stage to a consumer stage with explicit valid/busy handshakes on both sides. Replaces single-register skid buffering: depth is configurable, upstream busy is fully registered (no combinational path from downstream busy), and a synchronous flush discards in-flight entries on branch/exception redirect.

## Interface
- DW, 32, payload width in bits (≥1)
- DEPTH, 2, entry count; power of two, ≥2
- i_clock  in  1  clock; all state on rising edge
- i_reset  in  1  reset; asynchronous, active-high
- i_flush  in  1  synchronous discard of all entries
- i_valid  in  1  upstream presents an item
- i_tag  in  `TAG_SIZE  upstream tag
- i_data  in  DW  upstream payload
- o_busy  out  1  buffer cannot accept; registered
- o_valid  out  1  head item present
- o_tag  out  `TAG_SIZE  head tag
- o_data  out  DW  head payload
- i_busy  in  1  downstream cannot accept
- o_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push: i_valid && !o_busy && !i_flush. Entry {i_tag,i_data} written at write pointer; pointer advances mod DEPTH.
- Pop: o_valid && !i_busy && !i_flush. Read pointer advances mod DEPTH.
- o_busy = (count == DEPTH), from registered count only. When full, push is refused even if a pop occurs the same cycle; i_valid held by upstream.
- Push and pop same cycle: count unchanged, both pointers advance.
- o_valid = (count != 0) (plus bypass term, see Configuration); o_tag/o_data = entry at read pointer.
- Flush: pointers and count to 0 at next edge; concurrent push and pop ignored; o_valid low the cycle after flush.
- Pointers are $clog2(DEPTH) bits, wrap naturally; count is one bit wider, range 0..DEPTH, never over/underflows.
- Tags are opaque; no ordering or uniqueness check.

## Timing
- Reset (async assert): o_valid=0, o_busy=0, o_count=0, pointers=0, storage cleared so o_tag=0, o_data=0. Deassertion: first push accepted on first edge after.
- Registered path latency: push at edge N → o_valid at N+1 (if empty).
- Upstream throughput: 1 item/cycle while not full; downstream: 1 item/cycle while non-empty.
- Full → o_busy drops the cycle after the first pop from full.
- i_busy influences only pop; no combinational input-to-o_busy path.
- Reset asserted mid-transfer: all entries lost, outputs to reset values immediately.

## Configuration
- CPU_ELASTIC_BYPASS_EN defined: when count==0 and i_valid && !i_flush, o_valid=1 and o_tag/o_data = i_tag/i_data combinationally; if also !i_busy the item passes without being stored (count stays 0); if i_busy it is stored as a normal push. Zero-cycle latency when empty.
- Undefined: all items pass through storage; minimum latency 1 cycle; all outputs driven from registers.

## Structure
- Shared package (CPU_Defines / cpu package): `TAG_SIZE, a packed entry typedef {tag, data} macro/helper, and a pointer-width helper constant ($clog2(DEPTH)).
- One natural sub-module: cpu_elastic_buffer_ram, DEPTH×(TAG+DW) register array with one write and one async read port, cleared on reset.
- Control (pointers, count, flush, bypass) lives in cpu_elastic_buffer.

## Test plan
- DEPTH=4, DW=32, i_busy=1, push tags 1..5 back-to-back → tags 1..4 accepted, o_busy=1 from cycle after 4th push, o_count=4, tag 5 held.
- From full, i_busy=0 with i_valid held → o_tag sequence 1,2,3,4,5 in order, no loss/duplication, o_busy low one cycle after first pop.
- Continuous push+pop at half occupancy, 20 cycles, data=cycle index → o_count constant 2, output stream equals input stream delayed by 2 items, pointers wrap cleanly.
- Count=3, assert i_flush with i_valid=1 and i_busy=0 → next cycle o_count=0, o_valid=0, flushed-cycle item not stored.
- Empty, single push tag 7 data 0xDEADBEEF, i_busy=0 → without CPU_ELASTIC_BYPASS_EN o_valid at N+1, o_count=1 one cycle; with it o_valid same cycle, o_count stays 0.
- Async i_reset pulse between edges while count=2 → o_valid, o_busy, o_count, o_tag, o_data all 0 immediately.

Source files
------------

// File: rtl/cpu_elastic_buffer_pkg.sv
// Shared definitions for the CPU elastic buffer: tag width, entry layout and pointer sizing.
// `TAG_SIZE may be overridden on the command line; it defaults to 8 bits here.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

`ifndef CPU_EB_ENTRY_T
`define CPU_EB_ENTRY_T(DWID) struct packed { logic [`TAG_SIZE-1:0] tag; logic [(DWID)-1:0] data; }
`endif

package cpu_elastic_buffer_pkg;

    localparam int TAG_W = `TAG_SIZE;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int entry_w(input int dw);
        return TAG_W + dw;
    endfunction

endpackage

// File: rtl/cpu_elastic_buffer_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port,
// contents cleared by asynchronous reset so the head reads as zero after reset.
module cpu_elastic_buffer_ram
    import cpu_elastic_buffer_pkg::*;
#(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]            wdata_i,
    input  logic [ptr_w(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]            rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_elastic_buffer.sv
// N-entry elastic buffer between CPU pipeline stages with registered upstream busy and flush.
// Optional zero-latency bypass when empty is enabled by defining CPU_ELASTIC_BYPASS_EN.
module cpu_elastic_buffer
    import cpu_elastic_buffer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [`TAG_SIZE-1:0]   i_tag,
    input  logic [DW-1:0]          i_data,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [`TAG_SIZE-1:0]   o_tag,
    output logic [DW-1:0]          o_data,
    input  logic                   i_busy,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = entry_w(DW);

    typedef `CPU_EB_ENTRY_T(DW) entry_t;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    entry_t        wr_entry;
    logic [EW-1:0] rd_raw;
    entry_t        rd_entry;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic push_store;
    logic pop_store;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

`ifdef CPU_ELASTIC_BYPASS_EN
    assign bypass = empty && i_valid && !i_flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = i_valid && !full && !i_flush;
    assign pop  = o_valid && !i_busy && !i_flush;

    // A bypassed item consumed the same cycle never touches storage.
    assign push_store = push && !(bypass && !i_busy);
    assign pop_store  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_store) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop_store) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_store) - CW'(pop_store);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign wr_entry.tag  = i_tag;
    assign wr_entry.data = i_data;

    cpu_elastic_buffer_ram #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .we_i    (push_store),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q),
        .rdata_o (rd_raw)
    );

    assign rd_entry = rd_raw;

    assign o_busy  = full;
    assign o_count = count_q;
    assign o_valid = !empty || bypass;
    assign o_tag   = bypass ? i_tag  : rd_entry.tag;
    assign o_data  = bypass ? i_data : rd_entry.data;

endmodule
